seven_segment_scanner: RTL and testbench

Time-multiplexed display controller sharing one `seven_segments` decoder across `DIGITS` common-anode digits. It double-buffers a packed 4-bit-per-digit value and scans the digits round-robin, with a fixed dwell time per digit and a blanking gap between digits to suppress ghosting. Decoded segments and the digit enables are registered together and drive the board display pins directly. The block instantiates the existing `seven_segments` decoder internally.

---
 rtl/seven_segment_scanner.sv | 150 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode display driver: double-buffered nibble value,
// round-robin digit scan with a dark gap before each lit period.

module seven_segments (
    input  logic [3:0] value,
    output logic [6:0] segments
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        case (value)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'ha: segments = 7'b0001000;
            4'hb: segments = 7'b0000011;
            4'hc: segments = 7'b1000110;
            4'hd: segments = 7'b0100001;
            4'he: segments = 7'b0000110;
            default: segments = 7'b0001110;
        endcase
    end
endmodule

module seven_segment_scanner #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic [6:0]            segments,
    output logic                  frame_start
);
    localparam int MAXC  = (DIV > BLANK) ? DIV : BLANK;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t                 state, nxt_state;
    logic [CNT_W-1:0]       cnt, nxt_cnt;
    logic [IDX_W-1:0]       digit_idx, nxt_idx;
    logic [4*DIGITS-1:0]    pending, active, nxt_active;
    logic                   boundary;
    logic [3:0]             nib;
    logic [6:0]             dec_seg;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = digit_idx;
        boundary  = 1'b0;
        if (!enable) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    nxt_idx  = '0;
                    nxt_cnt  = '0;
                    boundary = 1'b1;
                    if (BLANK > 0) nxt_state = S_BLANK;
                    else           nxt_state = S_SHOW;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = S_SHOW;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt == DIV_LAST) begin
                        nxt_cnt = '0;
                        if (BLANK > 0) nxt_state = S_BLANK;
                        else           nxt_state = S_SHOW;
                        if (digit_idx == IDX_LAST) begin
                            nxt_idx  = '0;
                            boundary = 1'b1;
                        end else begin
                            nxt_idx = digit_idx + IDX_W'(1);
                        end
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Decode the nibble that will be visible after this edge, so the digit
    // enable and its segments update together.
    assign nxt_active = boundary ? pending : active;

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nxt_idx == IDX_W'(i)) nib = nxt_active[4*i +: 4];
        end
    end

    seven_segments u_dec (
        .value    (nib),
        .segments (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            pending     <= '0;
            active      <= '0;
            frame_start <= 1'b0;
            digit_sel_n <= {DIGITS{1'b1}};
            segments    <= 7'b1111111;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            digit_idx   <= nxt_idx;
            frame_start <= boundary;
            if (load)     pending <= value_in;
            if (boundary) active  <= pending;
            if (nxt_state == S_SHOW) begin
                digit_sel_n <= ~(DIGITS'(1) << nxt_idx);
                segments    <= dec_seg;
            end else begin
                digit_sel_n <= {DIGITS{1'b1}};
                segments    <= 7'b1111111;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: DIGITS=4, DIV=4, with BLANK=1
// and BLANK=0 instances sharing clock, reset and load inputs.

module tb_seven_segment_scanner;
    logic        clk;
    logic        rst_n;
    logic        en1, en0;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  sel1, sel0;
    logic [6:0]  seg1, seg0;
    logic        fs1, fs0;

    int total = 0;
    int bad   = 0;

    seven_segment_scanner #(.DIGITS(4), .DIV(4), .BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .load(load), .value_in(value_in),
        .digit_sel_n(sel1), .segments(seg1), .frame_start(fs1)
    );

    seven_segment_scanner #(.DIGITS(4), .DIV(4), .BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .load(load), .value_in(value_in),
        .digit_sel_n(sel0), .segments(seg0), .frame_start(fs0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Common-anode codes {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'ha: return 7'h08; 4'hb: return 7'h03;
            4'hc: return 7'h46; 4'hd: return 7'h21; 4'he: return 7'h06; default: return 7'h0e;
        endcase
    endfunction

    // Position p in a 20-cycle BLANK=1 frame: p%5==0 is the dark cycle.
    function automatic logic [11:0] exp_b1(input int p, input logic [15:0] v);
        logic [3:0] s;
        logic [6:0] g;
        if (p % 5 == 0) begin
            s = 4'b1111;
            g = 7'h7f;
        end else begin
            s = ~(4'b0001 << (p / 5));
            g = seg_code(v[4*(p/5) +: 4]);
        end
        return {s, g, (p == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        total++;
        if ({sel1, seg1, fs1} !== {4'b1111, 7'h7f, 1'b0}) begin
            bad++;
            $display("FAIL reset_initial got=%h want=%h", {sel1, seg1, fs1}, {4'b1111, 7'h7f, 1'b0});
        end
        en1 = 1'b1;
        tick(); tick(); tick();
        e = exp_b1(2, 16'h0000);
        total++;
        if ({sel1, seg1, fs1} !== e) begin
            bad++;
            $display("FAIL reset_preshow got=%h want=%h", {sel1, seg1, fs1}, e);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sel1, seg1, fs1} !== {4'b1111, 7'h7f, 1'b0}) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", {sel1, seg1, fs1}, {4'b1111, 7'h7f, 1'b0});
        end
        en1 = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({sel1, seg1, fs1} !== {4'b1111, 7'h7f, 1'b0}) begin
                bad++;
                $display("FAIL reset_release_dark c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, {4'b1111, 7'h7f, 1'b0});
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [11:0] e;
        value_in = 16'h3210;
        load = 1'b1;
        tick();
        en1 = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            tick();
            e = exp_b1(c % 20, 16'h3210);
            total++;
            if ({sel1, seg1, fs1} !== e) begin
                bad++;
                $display("FAIL basic_scan c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, e);
            end
        end
    endtask

    task automatic test_mid_frame_load();
        logic [11:0] e;
        logic [15:0] v;
        v = 16'h3210;
        for (int c = 1; c <= 39; c++) begin
            if (c == 7) begin
                value_in = 16'hdcba;
                load = 1'b1;
            end
            tick();
            if (c % 20 == 0) v = 16'hdcba;
            e = exp_b1(c % 20, v);
            total++;
            if ({sel1, seg1, fs1} !== e) begin
                bad++;
                $display("FAIL mid_frame_load c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, e);
            end
        end
    endtask

    task automatic test_load_on_boundary();
        logic [11:0] e;
        logic [15:0] v;
        v = 16'hdcba;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                value_in = 16'h7777;
                load = 1'b1;
            end
            if (c == 21) begin
                value_in = 16'h5555;
                load = 1'b1;
            end
            tick();
            if (c == 21) v = 16'h7777;
            if (c == 41) v = 16'h5555;
            e = exp_b1((19 + c) % 20, v);
            total++;
            if ({sel1, seg1, fs1} !== e) begin
                bad++;
                $display("FAIL load_on_boundary c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, e);
            end
        end
    endtask

    task automatic test_disable();
        logic [11:0] e;
        for (int c = 1; c <= 12; c++) begin
            tick();
            e = exp_b1((19 + c) % 20, 16'h5555);
            total++;
            if ({sel1, seg1, fs1} !== e) begin
                bad++;
                $display("FAIL disable_prefix c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, e);
            end
        end
        en1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({sel1, seg1, fs1} !== {4'b1111, 7'h7f, 1'b0}) begin
                bad++;
                $display("FAIL disable_dark c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, {4'b1111, 7'h7f, 1'b0});
            end
        end
        en1 = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            tick();
            e = exp_b1(c % 20, 16'h5555);
            total++;
            if ({sel1, seg1, fs1} !== e) begin
                bad++;
                $display("FAIL reenable c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, e);
            end
        end
        en1 = 1'b0;
        tick();
    endtask

    task automatic test_blank0();
        logic [11:0] e;
        int p;
        value_in = 16'h9876;
        load = 1'b1;
        tick();
        en0 = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            tick();
            p = c % 16;
            e = {~(4'b0001 << (p / 4)), seg_code(value_in[4*(p/4) +: 4]), (p == 0)};
            total++;
            if ({sel0, seg0, fs0} !== e) begin
                bad++;
                $display("FAIL blank0_scan c=%0d got=%h want=%h", c, {sel0, seg0, fs0}, e);
            end
            total++;
            if ({sel1, seg1, fs1} !== {4'b1111, 7'h7f, 1'b0}) begin
                bad++;
                $display("FAIL idle_dut_dark c=%0d got=%h want=%h", c, {sel1, seg1, fs1}, {4'b1111, 7'h7f, 1'b0});
            end
        end
        en0 = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        en1      = 1'b0;
        en0      = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;
        #2;
        test_reset_pre: begin end
        #10 rst_n = 1'b1;
        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_load_on_boundary();
        test_disable();
        test_blank0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
